can_rx_crc_ctrl: RTL and testbench

Receive-side frame sequencer for the CAN 2.0A CRC datapath. It consumes one sampled bus bit per strobe, removes stuff bits and tracks frame fields (SOF, ID, RTR, IDE, r0, DLC, data, CRC, delimiter). It feeds exactly the CRC-covered bits (SOF through end of data) into an internal `can_crc` instance, then compares the result against the received CRC sequence. It sits between the bit-timing/sampling logic and the frame buffer, and reports per-frame CRC, stuff and form status.

---
 rtl/can_pkg.sv | 35 +++
 rtl/can_crc.sv | 35 +++
 rtl/can_rx_crc_ctrl.sv | 268 ++++++++++++++++++++++++++
 tb/tb_can_rx_crc_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared constants, state encoding and the CRC-15 step function for the
// CAN 2.0A receive path.
package can_pkg;

    localparam int CAN_CRC_W           = 15;
    localparam int CAN_ID_W            = 11;
    localparam int CAN_DLC_W           = 4;
    localparam int CAN_MAX_DATA_BITS   = 64;
    localparam int CAN_IDLE_BITS_DEF   = 11;
    localparam int CAN_STUFF_LIMIT_DEF = 5;

    // x^15 + x^14 + x^10 + x^8 + x^7 + x^4 + x^3 + 1, leading term implied
    localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

    typedef logic [2:0] can_state_t;

    localparam can_state_t ST_WAIT_IDLE = 3'd0;
    localparam can_state_t ST_IDLE      = 3'd1;
    localparam can_state_t ST_ARB       = 3'd2;
    localparam can_state_t ST_CTRL      = 3'd3;
    localparam can_state_t ST_DATA      = 3'd4;
    localparam can_state_t ST_CRC       = 3'd5;
    localparam can_state_t ST_DELIM     = 3'd6;

    // One serial CRC-15 step: shift in one message bit MSB first
    function automatic logic [CAN_CRC_W-1:0] can_crc_step(
        input logic [CAN_CRC_W-1:0] crc,
        input logic                 din
    );
        logic fb;
        fb = din ^ crc[CAN_CRC_W-1];
        can_crc_step = {crc[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC_POLY : {CAN_CRC_W{1'b0}});
    endfunction

endpackage

// File: rtl/can_crc.sv
// Serial CAN CRC-15 generator: one message bit per enabled cycle.
module can_crc
    import can_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 din,
    output logic [CAN_CRC_W-1:0] crc
);

    logic [CAN_CRC_W-1:0] crc_q;
    logic [CAN_CRC_W-1:0] crc_d;

    // Next remainder: advance by one bit when enabled, otherwise hold
    always_comb begin
        if (en) begin
            crc_d = can_crc_step(crc_q, din);
        end else begin
            crc_d = crc_q;
        end
    end

    // Remainder register, cleared whenever the frame sequencer is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= {CAN_CRC_W{1'b0}};
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/can_rx_crc_ctrl.sv
// CAN 2.0A receive frame sequencer: destuffs the sampled bit stream, tracks
// frame fields, feeds the CRC-covered bits to can_crc and checks the
// received CRC sequence against the computed one.
module can_rx_crc_ctrl
    import can_pkg::*;
#(
    parameter int unsigned IDLE_BITS   = CAN_IDLE_BITS_DEF,
    parameter int unsigned STUFF_LIMIT = CAN_STUFF_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_strobe,
    input  logic                 rx_bit,
    output logic [CAN_ID_W-1:0]  rx_id,
    output logic                 rx_rtr,
    output logic [CAN_DLC_W-1:0] rx_dlc,
    output logic [CAN_CRC_W-1:0] crc_rx,
    output logic [CAN_CRC_W-1:0] crc_calc,
    output logic                 frame_done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic                 stuff_err,
    output logic                 form_err,
    output logic                 busy
);

    localparam logic [3:0] IDLE_LAST = 4'(IDLE_BITS - 1);
    localparam logic [3:0] RUN_MAX   = 4'(STUFF_LIMIT);

    can_state_t           state_q,    state_d;
    logic [3:0]           idle_cnt_q, idle_cnt_d;
    logic [6:0]           bit_cnt_q,  bit_cnt_d;
    logic [6:0]           data_len_q, data_len_d;
    logic [3:0]           run_len_q,  run_len_d;
    logic                 run_lvl_q,  run_lvl_d;
    logic [CAN_ID_W-1:0]  id_q,       id_d;
    logic                 rtr_q,      rtr_d;
    logic [CAN_DLC_W-1:0] dlc_q,      dlc_d;
    logic [CAN_CRC_W-1:0] crc_rx_q,   crc_rx_d;
    logic                 crc_en_q,   crc_en_d;
    logic                 crc_din_q,  crc_din_d;
    logic                 done_q,     done_d;
    logic                 ok_q,       ok_d;
    logic                 cerr_q,     cerr_d;
    logic                 serr_q,     serr_d;
    logic                 ferr_q,     ferr_d;
    logic                 busy_q,     busy_d;

    logic [CAN_DLC_W-1:0] dlc_new_s;
    logic [6:0]           data_len_s;
    logic                 crc_match_s;
    logic                 crc_rst_n_s;

    // DLC as it will look once the current bit is shifted in; the data
    // length saturates at 8 bytes and is zero for remote frames
    assign dlc_new_s   = {dlc_q[CAN_DLC_W-2:0], rx_bit};
    assign data_len_s  = rtr_q        ? 7'd0 :
                         dlc_new_s[3] ? 7'(CAN_MAX_DATA_BITS) :
                                        {1'b0, dlc_new_s[2:0], 3'b000};
    assign crc_match_s = (crc_rx_q == crc_calc);
    assign crc_rst_n_s = ~(rst | (state_q == ST_WAIT_IDLE));

    // Frame sequencing, destuffing and field capture, one step per strobe
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        data_len_d = data_len_q;
        run_len_d  = run_len_q;
        run_lvl_d  = run_lvl_q;
        id_d       = id_q;
        rtr_d      = rtr_q;
        dlc_d      = dlc_q;
        crc_rx_d   = crc_rx_q;
        crc_en_d   = 1'b0;
        crc_din_d  = 1'b0;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        cerr_d     = 1'b0;
        serr_d     = 1'b0;
        ferr_d     = 1'b0;
        if (bit_strobe) begin
            case (state_q)
                ST_WAIT_IDLE: begin
                    if (!rx_bit) begin
                        idle_cnt_d = 4'd0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        idle_cnt_d = 4'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (!rx_bit) begin
                        state_d   = ST_ARB;
                        crc_en_d  = 1'b1;
                        crc_din_d = 1'b0;
                        run_len_d = 4'd1;
                        run_lvl_d = 1'b0;
                        bit_cnt_d = 7'd0;
                        crc_rx_d  = {CAN_CRC_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ARB, ST_CTRL, ST_DATA, ST_CRC: begin
                    if (run_len_q == RUN_MAX) begin
                        // Stuff slot: must be the opposite level, then dropped
                        if (rx_bit == run_lvl_q) begin
                            serr_d     = 1'b1;
                            state_d    = ST_WAIT_IDLE;
                            idle_cnt_d = 4'd0;
                        end else begin
                            run_len_d = 4'd1;
                            run_lvl_d = rx_bit;
                        end
                    end else begin
                        run_lvl_d = rx_bit;
                        run_len_d = (rx_bit == run_lvl_q) ? (run_len_q + 4'd1) : 4'd1;
                        case (state_q)
                            ST_ARB: begin
                                crc_en_d  = 1'b1;
                                crc_din_d = rx_bit;
                                if (bit_cnt_q == 7'd11) begin
                                    rtr_d     = rx_bit;
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_CTRL;
                                end else begin
                                    id_d      = {id_q[CAN_ID_W-2:0], rx_bit};
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            ST_CTRL: begin
                                crc_en_d  = 1'b1;
                                crc_din_d = rx_bit;
                                if (bit_cnt_q == 7'd0) begin
                                    // Extended frames are not handled here
                                    if (rx_bit) begin
                                        ferr_d     = 1'b1;
                                        state_d    = ST_WAIT_IDLE;
                                        idle_cnt_d = 4'd0;
                                    end else begin
                                        bit_cnt_d = 7'd1;
                                    end
                                end else if (bit_cnt_q == 7'd1) begin
                                    bit_cnt_d = 7'd2;
                                end else begin
                                    dlc_d = dlc_new_s;
                                    if (bit_cnt_q == 7'd5) begin
                                        data_len_d = data_len_s;
                                        bit_cnt_d  = 7'd0;
                                        state_d    = (data_len_s == 7'd0) ? ST_CRC : ST_DATA;
                                    end else begin
                                        bit_cnt_d = bit_cnt_q + 7'd1;
                                    end
                                end
                            end
                            ST_DATA: begin
                                crc_en_d  = 1'b1;
                                crc_din_d = rx_bit;
                                if (bit_cnt_q == (data_len_q - 7'd1)) begin
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_CRC;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            ST_CRC: begin
                                crc_rx_d = {crc_rx_q[CAN_CRC_W-2:0], rx_bit};
                                if (bit_cnt_q == 7'd14) begin
                                    bit_cnt_d = 7'd0;
                                    state_d   = ST_DELIM;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 7'd1;
                                end
                            end
                            default: begin
                                state_d = ST_WAIT_IDLE;
                            end
                        endcase
                    end
                end
                ST_DELIM: begin
                    state_d    = ST_WAIT_IDLE;
                    idle_cnt_d = 4'd0;
                    if (rx_bit) begin
                        done_d = 1'b1;
                        ok_d   = crc_match_s;
                        cerr_d = ~crc_match_s;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_WAIT_IDLE;
                    idle_cnt_d = 4'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        busy_d = (state_d != ST_WAIT_IDLE) && (state_d != ST_IDLE);
    end

    // State, counters, captured fields and registered pulse outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT_IDLE;
            idle_cnt_q <= 4'd0;
            bit_cnt_q  <= 7'd0;
            data_len_q <= 7'd0;
            run_len_q  <= 4'd0;
            run_lvl_q  <= 1'b0;
            id_q       <= {CAN_ID_W{1'b0}};
            rtr_q      <= 1'b0;
            dlc_q      <= {CAN_DLC_W{1'b0}};
            crc_rx_q   <= {CAN_CRC_W{1'b0}};
            crc_en_q   <= 1'b0;
            crc_din_q  <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            cerr_q     <= 1'b0;
            serr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_len_q <= data_len_d;
            run_len_q  <= run_len_d;
            run_lvl_q  <= run_lvl_d;
            id_q       <= id_d;
            rtr_q      <= rtr_d;
            dlc_q      <= dlc_d;
            crc_rx_q   <= crc_rx_d;
            crc_en_q   <= crc_en_d;
            crc_din_q  <= crc_din_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            cerr_q     <= cerr_d;
            serr_q     <= serr_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    can_crc u_can_crc (
        .clk   (clk),
        .rst_n (crc_rst_n_s),
        .en    (crc_en_q),
        .din   (crc_din_q),
        .crc   (crc_calc)
    );

    assign rx_id      = id_q;
    assign rx_rtr     = rtr_q;
    assign rx_dlc     = dlc_q;
    assign crc_rx     = crc_rx_q;
    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign crc_err    = cerr_q;
    assign stuff_err  = serr_q;
    assign form_err   = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_can_rx_crc_ctrl.sv
// Directed bench for can_rx_crc_ctrl: table of whole frames plus hand-written
// stuff-error, idle-qualification and mid-frame reset sequences.
module tb_can_rx_crc_ctrl;

    logic        clk;
    logic        rst;
    logic        bit_strobe;
    logic        rx_bit;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [14:0] crc_rx;
    logic [14:0] crc_calc;
    logic        frame_done;
    logic        crc_ok;
    logic        crc_err;
    logic        stuff_err;
    logic        form_err;
    logic        busy;

    can_rx_crc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bit_strobe (bit_strobe),
        .rx_bit     (rx_bit),
        .rx_id      (rx_id),
        .rx_rtr     (rx_rtr),
        .rx_dlc     (rx_dlc),
        .crc_rx     (crc_rx),
        .crc_calc   (crc_calc),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .stuff_err  (stuff_err),
        .form_err   (form_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] id;
        logic        rtr;
        logic        ide;
        logic [3:0]  dlc;
        logic [63:0] data;
        int          flip;
        logic        delim;
        logic        exp_done;
        logic        exp_ok;
        logic        exp_err;
        logic        exp_ferr;
        int          exp_en;
    } vec_t;

    vec_t vecs[8];

    int n_cmp = 0;
    int n_bad = 0;

    int en_cnt, done_cnt, ok_cnt, cerr_cnt, serr_cnt, ferr_cnt;
    logic snap_done, snap_ok, snap_err, snap_serr, snap_ferr;

    logic        fr_bits[$];
    int          fr_uidx[$];
    logic [14:0] fr_crc_gold;
    logic [14:0] fr_crc_tx;

    // Count every pulse the DUT emits, sampled away from the active edge
    always @(negedge clk) begin
        if (dut.crc_en_q) en_cnt++;
        if (frame_done)   done_cnt++;
        if (crc_ok)       ok_cnt++;
        if (crc_err)      cerr_cnt++;
        if (stuff_err)    serr_cnt++;
        if (form_err)     ferr_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        en_cnt = 0; done_cnt = 0; ok_cnt = 0; cerr_cnt = 0; serr_cnt = 0; ferr_cnt = 0;
    endtask

    // One bus bit: strobe for one cycle, snapshot the pulses one cycle later,
    // keep strobes four cycles apart
    task automatic send_bit(input logic b);
        @(negedge clk);
        rx_bit     = b;
        bit_strobe = 1'b1;
        @(negedge clk);
        bit_strobe = 1'b0;
        snap_done  = frame_done;
        snap_ok    = crc_ok;
        snap_err   = crc_err;
        snap_serr  = stuff_err;
        snap_ferr  = form_err;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Build SOF..CRC, compute the CRC by polynomial long division, then stuff
    task automatic build_frame(input logic [10:0] id, input logic rtr, input logic ide,
                               input logic [3:0] dlc, input logic [63:0] data, input int flip);
        logic        u[$];
        logic        m[$];
        logic [15:0] g;
        int          nd, n, run;
        logic        lvl;
        u = {};
        u.push_back(1'b0);
        for (int i = 10; i >= 0; i--) u.push_back(id[i]);
        u.push_back(rtr);
        u.push_back(ide);
        u.push_back(1'b0);
        for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
        nd = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc)) * 8;
        for (int i = 0; i < nd; i++) u.push_back(data[63-i]);
        n = u.size();
        m = u;
        for (int i = 0; i < 15; i++) m.push_back(1'b0);
        g = 16'hC599;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                for (int j = 0; j < 16; j++) m[i+j] = m[i+j] ^ g[15-j];
            end
        end
        for (int k = 0; k < 15; k++) fr_crc_gold[14-k] = m[n+k];
        fr_crc_tx = fr_crc_gold;
        if (flip >= 0) fr_crc_tx[flip] = ~fr_crc_tx[flip];
        for (int k = 14; k >= 0; k--) u.push_back(fr_crc_tx[k]);
        fr_bits = {};
        fr_uidx = {};
        run = 0;
        lvl = 1'b1;
        for (int i = 0; i < u.size(); i++) begin
            if (run == 5) begin
                fr_bits.push_back(~lvl);
                fr_uidx.push_back(-1);
                lvl = ~lvl;
                run = 1;
            end
            fr_bits.push_back(u[i]);
            fr_uidx.push_back(i);
            if (u[i] == lvl) begin
                run++;
            end else begin
                run = 1;
                lvl = u[i];
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        logic [14:0] calc_s;
        for (int i = 0; i < 11; i++) send_bit(1'b1);
        clear_counts();
        build_frame(v.id, v.rtr, v.ide, v.dlc, v.data, v.flip);
        for (int i = 0; i < fr_bits.size(); i++) begin
            send_bit(fr_bits[i]);
            if (i == 2) chk($sformatf("v%0d busy_mid", tag), 64'(busy), 64'd1);
        end
        calc_s = crc_calc;
        send_bit(v.delim);
        if (v.exp_done) begin
            chk($sformatf("v%0d done_pulse", tag), 64'(snap_done), 64'd1);
            chk($sformatf("v%0d ok_pulse", tag), 64'(snap_ok), 64'(v.exp_ok));
            chk($sformatf("v%0d err_pulse", tag), 64'(snap_err), 64'(v.exp_err));
        end
        if (!v.ide) begin
            chk($sformatf("v%0d ferr_pulse", tag), 64'(snap_ferr), 64'(v.exp_ferr));
            chk($sformatf("v%0d crc_calc", tag), 64'(calc_s), 64'(fr_crc_gold));
        end
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d done_cnt", tag), 64'(done_cnt), 64'(v.exp_done));
        chk($sformatf("v%0d ok_cnt", tag), 64'(ok_cnt), 64'(v.exp_ok));
        chk($sformatf("v%0d cerr_cnt", tag), 64'(cerr_cnt), 64'(v.exp_err));
        chk($sformatf("v%0d ferr_cnt", tag), 64'(ferr_cnt), 64'(v.exp_ferr));
        chk($sformatf("v%0d serr_cnt", tag), 64'(serr_cnt), 64'd0);
        if (v.exp_en >= 0) chk($sformatf("v%0d crc_en_cnt", tag), 64'(en_cnt), 64'(v.exp_en));
        chk($sformatf("v%0d rx_id", tag), 64'(rx_id), 64'(v.id));
        if (v.exp_done) begin
            chk($sformatf("v%0d rx_rtr", tag), 64'(rx_rtr), 64'(v.rtr));
            chk($sformatf("v%0d rx_dlc", tag), 64'(rx_dlc), 64'(v.dlc));
            chk($sformatf("v%0d crc_rx", tag), 64'(crc_rx), 64'(fr_crc_tx));
        end
        chk($sformatf("v%0d busy_end", tag), 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        all_outs = 64'({rx_id, rx_rtr, rx_dlc, crc_rx, crc_calc,
                        frame_done, crc_ok, crc_err, stuff_err, form_err, busy});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        id      rtr   ide   dlc   data                     flip delim done  ok    err   ferr  en
        vecs[0] = '{11'h123, 1'b0, 1'b0, 4'd1,  64'hA500_0000_0000_0000, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 27};
        vecs[1] = '{11'h123, 1'b0, 1'b0, 4'd1,  64'hA500_0000_0000_0000,  3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 27};
        vecs[2] = '{11'h555, 1'b1, 1'b0, 4'd8,  64'hFFFF_0000_FFFF_0000, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19};
        vecs[3] = '{11'h7F0, 1'b0, 1'b0, 4'd15, 64'h0123_4567_89AB_CDEF, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 83};
        vecs[4] = '{11'h000, 1'b0, 1'b0, 4'd0,  64'h0,                   -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19};
        vecs[5] = '{11'h6A1, 1'b0, 1'b0, 4'd8,  64'hFFFF_FFFF_0000_0000, -1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 83};
        vecs[6] = '{11'h123, 1'b0, 1'b1, 4'd1,  64'hA500_0000_0000_0000, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1};
        vecs[7] = '{11'h3FF, 1'b0, 1'b0, 4'd2,  64'hBEEF_0000_0000_0000, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 35};

        rst        = 1'b1;
        bit_strobe = 1'b0;
        rx_bit     = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_outputs", all_outs(), 64'd0);

        for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

        // Stuff error: ID 0 gives five dominant bits, the stuff slot is dominant too
        for (int i = 0; i < 11; i++) send_bit(1'b1);
        clear_counts();
        build_frame(11'h000, 1'b0, 1'b0, 4'd0, 64'h0, -1);
        chk("stuff_slot_index", 64'(fr_uidx[5]), 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 5; i++) send_bit(fr_bits[i]);
        chk("busy_before_stuff", 64'(busy), 64'd1);
        send_bit(1'b0);
        chk("stuff_err_pulse", 64'(snap_serr), 64'd1);
        chk("stuff_busy_drop", 64'(busy), 64'd0);
        chk("stuff_err_cnt", 64'(serr_cnt), 64'd1);

        // Only ten recessive bits: the dominant bit is not a SOF
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        send_bit(1'b0);
        chk("no_sof_after_10", 64'(busy), 64'd0);

        // Eleven recessive bits, then a frame that gets reset mid-DATA
        for (int i = 0; i < 11; i++) send_bit(1'b1);
        build_frame(11'h123, 1'b0, 1'b0, 4'd1, 64'hA500_0000_0000_0000, -1);
        send_bit(fr_bits[0]);
        chk("sof_after_11", 64'(busy), 64'd1);
        for (int i = 1; i < fr_bits.size(); i++) begin
            send_bit(fr_bits[i]);
            if (fr_uidx[i] == 22) break;
        end
        chk("mid_data_dlc", 64'(rx_dlc), 64'd1);
        chk("mid_data_busy", 64'(busy), 64'd1);
        clear_counts();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_data_outputs", all_outs(), 64'd0);
        chk("rst_mid_data_id", 64'(rx_id), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_no_pulses", 64'(done_cnt + serr_cnt + ferr_cnt + cerr_cnt + ok_cnt), 64'd0);

        // After reset a dominant bit before eleven recessive ones is ignored
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        chk("no_sof_after_reset", 64'(busy), 64'd0);
        run_vec(vecs[0], 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
